// File: rtl/bcd_gray_pkg.sv
// bcd_gray_pkg: shared FSM states and BCD validity helper for the BCD-to-Gray arbiter.
package bcd_gray_pkg;
    typedef enum logic [1:0] {IDLE, CONV, RESP} state_e;
    localparam logic [3:0] BCD_MAX = 4'd9;
    function automatic logic bcd_invalid(input logic [3:0] digit);
        return digit > BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd2gray_core.sv
// bcd2gray_core: combinational 4-bit BCD-to-Gray conversion with invalid-digit flag.
module bcd2gray_core
    import bcd_gray_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [3:0] gray_o,
    output logic       err_o
);
    assign gray_o = bcd_i ^ (bcd_i >> 1);
    assign err_o  = bcd_invalid(bcd_i);
endmodule

// File: rtl/bcd_gray_arbiter.sv
// bcd_gray_arbiter: round-robin shares one registered BCD-to-Gray stage among NUM_REQ
// requesters, returning Gray code, requester ID and invalid flag on one response port.
module bcd_gray_arbiter
    import bcd_gray_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ERR_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [3:0]           rsp_gray,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err,
    output logic [ERR_W-1:0]     err_cnt,
    output logic                 busy
);
    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, grant_id_q, rsp_id_q, sel, cand;
    logic [3:0]        digit_q, rsp_gray_q, gray;
    logic [3:0]        digits [NUM_REQ];
    logic              rsp_err_q, err, found;
    logic [ERR_W-1:0]  err_cnt_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_dig
        assign digits[i] = req_data[4*i +: 4];
    end

    // Scan from the far end so the candidate nearest rr_ptr is written last and wins.
    always_comb begin
        sel = '0;
        found = 1'b0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                sel = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = found ? CONV : IDLE;
            CONV:    state_d = RESP;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    bcd2gray_core u_core (
        .bcd_i  (digit_q),
        .gray_o (gray),
        .err_o  (err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            digit_q    <= '0;
            rsp_gray_q <= '0;
            rsp_id_q   <= '0;
            rsp_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && found) begin
                digit_q    <= digits[sel];
                grant_id_q <= sel;
            end
            if (state_q == CONV) begin
                rsp_gray_q <= gray;
                rsp_err_q  <= err;
                rsp_id_q   <= grant_id_q;
                if (err && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (state_q == RESP && rsp_ready)
                rr_ptr_q <= (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        end
    end

    assign req_ready = (state_q == IDLE && found) ? NUM_REQ'(1) << sel : '0;
    assign rsp_valid = state_q == RESP;
    assign busy      = state_q != IDLE;
    assign rsp_gray  = rsp_gray_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_bcd_gray_arbiter.sv
// tb_bcd_gray_arbiter: random and directed stimulus checked every cycle against a behavioural model.
module tb_bcd_gray_arbiter;
    localparam int N = 4, IW = 2, EW = 8;
    localparam int CMAX = (1 << EW) - 1;

    logic            clk = 1'b0, rst = 1'b1, rsp_ready = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [4*N-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic            rsp_valid, rsp_err, busy;
    logic [3:0]      rsp_gray;
    logic [IW-1:0]   rsp_id;
    logic [EW-1:0]   err_cnt;

    always #5 clk = ~clk;

    bcd_gray_arbiter #(.NUM_REQ(N), .ID_W(IW), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gray(rsp_gray), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .err_cnt(err_cnt), .busy(busy)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;
    // Model: phase 0 waiting for grant, 1 converting, 2 presenting a response.
    int m_ph = 0, m_ptr = 0, m_gid = 0, m_rid = 0, m_cnt = 0, g;
    logic [3:0] m_digit = '0, m_gray = '0;
    logic m_err = 1'b0;
    logic [N-1:0] exp_ready;
    int gnt_q[$], rsp_cyc_q[$];
    logic [3:0] rgray_q[$];

    function automatic int rr_pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_ph = 0; m_ptr = 0; m_gid = 0; m_rid = 0; m_cnt = 0;
            m_digit = '0; m_gray = '0; m_err = 1'b0;
        end
        g = (m_ph == 0) ? rr_pick(req_valid, m_ptr) : -1;
        exp_ready = (g >= 0) ? N'(1) << g : '0;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_gray, rsp_id, rsp_err, err_cnt, busy} !==
            {exp_ready, m_ph == 2, m_gray, IW'(m_rid), m_err, EW'(m_cnt), m_ph != 0}) begin
            n_fail++;
            $display("FAIL model cyc=%0d got rdy=%b vld=%b gray=%b id=%0d err=%b cnt=%0d busy=%b exp rdy=%b vld=%0d gray=%b id=%0d err=%b cnt=%0d busy=%0d",
                     cyc, req_ready, rsp_valid, rsp_gray, rsp_id, rsp_err, err_cnt, busy,
                     exp_ready, m_ph == 2, m_gray, m_rid, m_err, m_cnt, m_ph != 0);
        end
        if (!rst) begin
            if (m_ph == 0 && g >= 0) begin
                m_digit = req_data[4*g +: 4];
                m_gid = g;
                m_ph = 1;
                gnt_q.push_back(g);
            end else if (m_ph == 1) begin
                m_gray = m_digit ^ (m_digit >> 1);
                m_err = m_digit > 9;
                m_rid = m_gid;
                if (m_err && m_cnt < CMAX) m_cnt++;
                m_ph = 2;
            end else if (m_ph == 2 && rsp_ready) begin
                m_ptr = (m_gid + 1) % N;
                m_ph = 0;
                rsp_cyc_q.push_back(cyc);
                rgray_q.push_back(m_gray);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic do_req(int id, logic [3:0] d, logic [3:0] xg, logic xe);
        int t;
        req_valid = N'(1) << id;
        req_data = N'(0);
        req_data[4*id +: 4] = d;
        #1;
        t = 0;
        while (req_ready[id] !== 1'b1 && t < 20) begin step(); t++; end
        if (t == 20) chk("grant_timeout", 0, 1);
        step();
        req_valid = '0;
        t = 0;
        while (rsp_valid !== 1'b1 && t < 10) begin step(); t++; end
        if (t == 10) chk("rsp_timeout", 0, 1);
        chk("req_gray", rsp_gray, xg);
        chk("req_err", rsp_err, xe);
        chk("req_id", rsp_id, id);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] hg;
        logic [IW-1:0] hid;
        int t;
        #1;
        chk("reset_outs", {req_ready, rsp_valid, rsp_gray, rsp_id, rsp_err, err_cnt, busy}, 0);
        do_reset();

        // Single request from requester 1, digit 9.
        req_valid = 4'b0010; req_data = 16'h0090;
        #1;
        chk("single_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        chk("single_conv_vld", rsp_valid, 0);
        chk("single_busy", busy, 1);
        step();
        chk("single_vld", rsp_valid, 1);
        chk("single_gray", rsp_gray, 4'b1101);
        chk("single_id", rsp_id, 1);
        chk("single_err", rsp_err, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("single_idle", busy, 0);

        do_req(2, 4'b1100, 4'b1010, 1'b1);
        chk("inv_cnt", err_cnt, 1);

        // Round-robin with all four requesting continuously.
        do_reset();
        gnt_q.delete(); rsp_cyc_q.delete(); rgray_q.delete();
        req_valid = 4'hF; req_data = 16'h0753; rsp_ready = 1'b1;
        repeat (15) step();
        req_valid = '0;
        repeat (4) step();
        rsp_ready = 1'b0;
        chk("rr_ngrant", gnt_q.size() >= 5, 1);
        chk("rr_nrsp", rgray_q.size() >= 4, 1);
        if (gnt_q.size() >= 5 && rgray_q.size() >= 4) begin
            chk("rr_g0", gnt_q[0], 0); chk("rr_g1", gnt_q[1], 1); chk("rr_g2", gnt_q[2], 2);
            chk("rr_g3", gnt_q[3], 3); chk("rr_g4", gnt_q[4], 0);
            chk("rr_r0", rgray_q[0], 4'b0010); chk("rr_r1", rgray_q[1], 4'b0111);
            chk("rr_r2", rgray_q[2], 4'b0100); chk("rr_r3", rgray_q[3], 4'b0000);
            for (int i = 0; i < 3; i++) chk("rr_space", rsp_cyc_q[i+1] - rsp_cyc_q[i], 3);
        end

        // Back-pressure with all requesters asserting.
        req_valid = 4'hF; req_data = 16'($urandom); rsp_ready = 1'b0;
        t = 0;
        while (rsp_valid !== 1'b1 && t < 10) begin step(); t++; end
        if (t == 10) chk("bp_timeout", 0, 1);
        hg = rsp_gray; hid = rsp_id;
        repeat (10) begin
            step();
            chk("bp_vld", rsp_valid, 1);
            chk("bp_gray", rsp_gray, hg);
            chk("bp_id", rsp_id, hid);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0; req_valid = '0;
        #1;
        chk("bp_done_vld", rsp_valid, 0);
        chk("bp_done_busy", busy, 0);

        // Reset while requester 3's digit is in CONV.
        req_valid = 4'b1000; req_data = 16'h6000;
        #1;
        t = 0;
        while (req_ready[3] !== 1'b1 && t < 20) begin step(); t++; end
        step();
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {req_ready, rsp_valid, rsp_gray, rsp_id, rsp_err, err_cnt, busy}, 0);
        req_valid = 4'b1001;
        step(); step();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 4'b0001);
        req_valid = '0;
        repeat (3) begin step(); chk("post_rst_vld", rsp_valid, 0); end

        // Saturation of the invalid-digit counter.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            logic [3:0] d;
            d = 4'($urandom_range(10, 15));
            do_req(int'($urandom_range(0, N - 1)), d, d ^ (d >> 1), 1'b1);
            if (i == 254) chk("sat_254", err_cnt, 8'hFF);
        end
        chk("sat_hold", err_cnt, 8'hFF);

        // Every digit from every requester.
        for (int id = 0; id < N; id++)
            for (int d = 0; d < 16; d++)
                do_req(id, 4'(d), 4'(d ^ (d >> 1)), d > 9);

        // Random traffic with occasional resets; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            req_valid = N'($urandom);
            req_data = 16'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
